// File: rtl/product_accumulator_if.sv
// Valid/ready bus between the multiplier, the product accumulator and its sum consumer.
interface product_accumulator_if #(
  parameter int ACC_W = 12
);
  logic             in_valid;
  logic             in_ready;
  logic [7:0]       product;
  logic             out_valid;
  logic             out_ready;
  logic [ACC_W-1:0] sum;
  logic             overflow;
  logic [3:0]       count;

  modport slave (
    input  in_valid,
    input  product,
    input  out_ready,
    output in_ready,
    output out_valid,
    output sum,
    output overflow,
    output count
  );

  modport master (
    output in_valid,
    output product,
    output out_ready,
    input  in_ready,
    input  out_valid,
    input  sum,
    input  overflow,
    input  count
  );
endinterface

// File: rtl/product_accumulator.sv
// Sums batches of N_TERMS multiplier products and presents each batch sum on a
// valid/ready output, holding it until the consumer takes it.
module product_accumulator #(
  parameter int N_TERMS = 4,
  parameter int ACC_W   = 12
) (
  input  logic                  clk,
  input  logic                  rst,
  product_accumulator_if.slave  bus
);

  typedef enum logic {
    ACCUM = 1'b0,
    HOLD  = 1'b1
  } state_t;

  state_t           r_state;
  state_t           w_nextState;
  logic [ACC_W-1:0] r_sum;
  logic             r_overflow;
  logic [3:0]       r_count;

  logic             w_inReady;
  logic             w_outValid;
  logic             w_inFire;
  logic             w_outFire;
  logic             w_lastTerm;
  logic [ACC_W:0]   w_productExt;
  logic [ACC_W:0]   w_addWide;

  assign w_inFire     = bus.in_valid && w_inReady;
  assign w_outFire    = w_outValid && bus.out_ready;
  assign w_lastTerm   = (r_count == 4'(N_TERMS - 1));
  // One extra bit captures the carry-out that feeds the sticky overflow flag.
  assign w_productExt = (ACC_W + 1)'(bus.product);
  assign w_addWide    = {1'b0, r_sum} + w_productExt;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ACCUM;
    end else begin
      r_state <= w_nextState;
    end
  end

  always_comb begin
    w_nextState = r_state;
    case (r_state)
      ACCUM:   if (w_inFire && w_lastTerm) w_nextState = HOLD;
      HOLD:    if (w_outFire) w_nextState = ACCUM;
      default: w_nextState = ACCUM;
    endcase
  end

  // Handshake outputs decode state only; rst masks in_ready so nothing is taken during reset.
  always_comb begin
    w_inReady  = 1'b0;
    w_outValid = 1'b0;
    case (r_state)
      ACCUM:   w_inReady  = !rst;
      HOLD:    w_outValid = 1'b1;
      default: begin
        w_inReady  = 1'b0;
        w_outValid = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_sum      <= '0;
      r_overflow <= 1'b0;
      r_count    <= 4'd0;
    end else if (w_inFire) begin
      r_sum      <= w_addWide[ACC_W-1:0];
      r_overflow <= r_overflow | w_addWide[ACC_W];
      r_count    <= w_lastTerm ? 4'd0 : r_count + 4'd1;
    end else if (w_outFire) begin
      r_sum      <= '0;
      r_overflow <= 1'b0;
    end
  end

  assign bus.in_ready  = w_inReady;
  assign bus.out_valid = w_outValid;
  assign bus.sum       = r_sum;
  assign bus.overflow  = r_overflow;
  assign bus.count     = r_count;

endmodule

// File: tb/tb_product_accumulator.sv
// Self-checking bench for product_accumulator: directed scenarios on a default
// (N=4, W=12) instance plus randomized batches on a narrow (N=4, W=9) instance.
module tb_product_accumulator;

  logic clk;
  logic rst;
  int   nTests;
  int   nFail;

  product_accumulator_if #(.ACC_W(12)) busA();
  product_accumulator_if #(.ACC_W(9))  busB();

  product_accumulator #(.N_TERMS(4), .ACC_W(12)) dutA (
    .clk (clk),
    .rst (rst),
    .bus (busA)
  );

  product_accumulator #(.N_TERMS(4), .ACC_W(9)) dutB (
    .clk (clk),
    .rst (rst),
    .bus (busB)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one cycle; outputs are then sampled and inputs driven 1 time unit after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick();
    nTests++; if (busA.in_ready !== 1'b0) begin nFail++; $display("[TB] FAIL reset_in_ready: got %0d expected 0", busA.in_ready); end
    nTests++; if (busA.out_valid !== 1'b0) begin nFail++; $display("[TB] FAIL reset_out_valid: got %0d expected 0", busA.out_valid); end
    nTests++; if (busA.sum !== 12'd0) begin nFail++; $display("[TB] FAIL reset_sum: got %0d expected 0", busA.sum); end
    nTests++; if (busA.count !== 4'd0) begin nFail++; $display("[TB] FAIL reset_count: got %0d expected 0", busA.count); end
    nTests++; if (busA.overflow !== 1'b0) begin nFail++; $display("[TB] FAIL reset_overflow: got %0d expected 0", busA.overflow); end
    rst = 1'b0;
    tick();
    nTests++; if (busA.in_ready !== 1'b1) begin nFail++; $display("[TB] FAIL post_reset_in_ready: got %0d expected 1", busA.in_ready); end
  endtask

  // Leaves dutA in HOLD with sum 50 for the back-pressure scenario.
  task automatic test_basic_batch();
    int prods[4] = '{15, 22, 9, 4};
    int running = 0;
    for (int i = 0; i < 4; i++) begin
      busA.in_valid = 1'b1;
      busA.product  = 8'(prods[i]);
      tick();
      running += prods[i];
      nTests++; if (busA.count !== 4'((i + 1) % 4)) begin nFail++; $display("[TB] FAIL basic_count[%0d]: got %0d expected %0d", i, busA.count, (i + 1) % 4); end
      nTests++; if (busA.sum !== 12'(running)) begin nFail++; $display("[TB] FAIL basic_partial[%0d]: got %0d expected %0d", i, busA.sum, running); end
      nTests++; if (busA.out_valid !== (i == 3)) begin nFail++; $display("[TB] FAIL basic_out_valid[%0d]: got %0d expected %0d", i, busA.out_valid, i == 3); end
    end
    busA.in_valid = 1'b0;
    nTests++; if (busA.sum !== 12'd50) begin nFail++; $display("[TB] FAIL basic_sum: got %0d expected 50", busA.sum); end
    nTests++; if (busA.overflow !== 1'b0) begin nFail++; $display("[TB] FAIL basic_overflow: got %0d expected 0", busA.overflow); end
    nTests++; if (busA.in_ready !== 1'b0) begin nFail++; $display("[TB] FAIL basic_in_ready_hold: got %0d expected 0", busA.in_ready); end
  endtask

  task automatic test_backpressure();
    busA.out_ready = 1'b0;
    busA.in_valid  = 1'b1;
    busA.product   = 8'd200;
    for (int i = 0; i < 5; i++) begin
      tick();
      nTests++; if (busA.in_ready !== 1'b0) begin nFail++; $display("[TB] FAIL bp_in_ready[%0d]: got %0d expected 0", i, busA.in_ready); end
      nTests++; if (busA.out_valid !== 1'b1) begin nFail++; $display("[TB] FAIL bp_out_valid[%0d]: got %0d expected 1", i, busA.out_valid); end
      nTests++; if (busA.sum !== 12'd50) begin nFail++; $display("[TB] FAIL bp_sum[%0d]: got %0d expected 50", i, busA.sum); end
    end
    busA.in_valid  = 1'b0;
    busA.out_ready = 1'b1;
    tick();
    busA.out_ready = 1'b0;
    nTests++; if (busA.out_valid !== 1'b0) begin nFail++; $display("[TB] FAIL bp_release_out_valid: got %0d expected 0", busA.out_valid); end
    nTests++; if (busA.sum !== 12'd0) begin nFail++; $display("[TB] FAIL bp_release_sum: got %0d expected 0", busA.sum); end
    nTests++; if (busA.in_ready !== 1'b1) begin nFail++; $display("[TB] FAIL bp_release_in_ready: got %0d expected 1", busA.in_ready); end
  endtask

  task automatic test_gapped();
    int prods[4] = '{15, 22, 9, 4};
    int gaps[4]  = '{0, 3, 0, 0};
    int running  = 0;
    for (int i = 0; i < 4; i++) begin
      busA.in_valid = 1'b0;
      for (int g = 0; g < gaps[i]; g++) begin
        tick();
        nTests++; if (busA.count !== 4'(i)) begin nFail++; $display("[TB] FAIL gap_count[%0d]: got %0d expected %0d", g, busA.count, i); end
        nTests++; if (busA.sum !== 12'(running)) begin nFail++; $display("[TB] FAIL gap_sum[%0d]: got %0d expected %0d", g, busA.sum, running); end
      end
      busA.in_valid = 1'b1;
      busA.product  = 8'(prods[i]);
      tick();
      running += prods[i];
    end
    busA.in_valid = 1'b0;
    nTests++; if (busA.out_valid !== 1'b1) begin nFail++; $display("[TB] FAIL gapped_out_valid: got %0d expected 1", busA.out_valid); end
    nTests++; if (busA.sum !== 12'd50) begin nFail++; $display("[TB] FAIL gapped_sum: got %0d expected 50", busA.sum); end
    busA.out_ready = 1'b1;
    tick();
    busA.out_ready = 1'b0;
  endtask

  task automatic test_reset_mid_batch();
    int prods[4] = '{1, 2, 3, 4};
    busA.in_valid = 1'b1;
    busA.product  = 8'd15;
    tick();
    busA.product  = 8'd22;
    tick();
    busA.in_valid = 1'b0;
    rst = 1'b1;
    #1;
    nTests++; if (busA.in_ready !== 1'b0) begin nFail++; $display("[TB] FAIL midrst_in_ready: got %0d expected 0", busA.in_ready); end
    tick();
    rst = 1'b0;
    nTests++; if (busA.sum !== 12'd0) begin nFail++; $display("[TB] FAIL midrst_sum: got %0d expected 0", busA.sum); end
    nTests++; if (busA.count !== 4'd0) begin nFail++; $display("[TB] FAIL midrst_count: got %0d expected 0", busA.count); end
    nTests++; if (busA.out_valid !== 1'b0) begin nFail++; $display("[TB] FAIL midrst_out_valid: got %0d expected 0", busA.out_valid); end
    nTests++; if (busA.overflow !== 1'b0) begin nFail++; $display("[TB] FAIL midrst_overflow: got %0d expected 0", busA.overflow); end
    for (int i = 0; i < 4; i++) begin
      busA.in_valid = 1'b1;
      busA.product  = 8'(prods[i]);
      tick();
    end
    busA.in_valid = 1'b0;
    nTests++; if (busA.out_valid !== 1'b1) begin nFail++; $display("[TB] FAIL midrst_batch_valid: got %0d expected 1", busA.out_valid); end
    nTests++; if (busA.sum !== 12'd10) begin nFail++; $display("[TB] FAIL midrst_batch_sum: got %0d expected 10", busA.sum); end
    busA.out_ready = 1'b1;
    tick();
    busA.out_ready = 1'b0;
  endtask

  task automatic test_overflow();
    int prods[4] = '{225, 225, 225, 1};
    for (int i = 0; i < 4; i++) begin
      busB.in_valid = 1'b1;
      busB.product  = 8'(prods[i]);
      tick();
    end
    busB.in_valid = 1'b0;
    nTests++; if (busB.out_valid !== 1'b1) begin nFail++; $display("[TB] FAIL ovf_out_valid: got %0d expected 1", busB.out_valid); end
    nTests++; if (busB.sum !== 9'd164) begin nFail++; $display("[TB] FAIL ovf_sum: got %0d expected 164", busB.sum); end
    nTests++; if (busB.overflow !== 1'b1) begin nFail++; $display("[TB] FAIL ovf_flag: got %0d expected 1", busB.overflow); end
    busB.out_ready = 1'b1;
    tick();
    busB.out_ready = 1'b0;
    nTests++; if (busB.overflow !== 1'b0) begin nFail++; $display("[TB] FAIL ovf_cleared: got %0d expected 0", busB.overflow); end
    nTests++; if (busB.sum !== 9'd0) begin nFail++; $display("[TB] FAIL ovf_sum_cleared: got %0d expected 0", busB.sum); end
  endtask

  // Steady stream of 10s with the consumer always ready: a batch completes every fifth edge.
  task automatic test_back_to_back();
    bit expValid;
    busA.out_ready = 1'b1;
    busA.in_valid  = 1'b1;
    busA.product   = 8'd10;
    for (int t = 1; t <= 15; t++) begin
      tick();
      expValid = ((t % 5) == 4);
      nTests++; if (busA.out_valid !== expValid) begin nFail++; $display("[TB] FAIL b2b_out_valid[%0d]: got %0d expected %0d", t, busA.out_valid, expValid); end
      nTests++; if (busA.in_ready !== !expValid) begin nFail++; $display("[TB] FAIL b2b_in_ready[%0d]: got %0d expected %0d", t, busA.in_ready, !expValid); end
      if (expValid) begin
        nTests++; if (busA.sum !== 12'd40) begin nFail++; $display("[TB] FAIL b2b_sum[%0d]: got %0d expected 40", t, busA.sum); end
      end
    end
    busA.in_valid  = 1'b0;
    busA.out_ready = 1'b0;
    nTests++; if (busA.sum !== 12'd0 || busA.count !== 4'd0) begin nFail++; $display("[TB] FAIL b2b_end_state: got sum %0d count %0d expected 0 0", busA.sum, busA.count); end
  endtask

  // Reference: a batch's sum is its true total modulo 512, and overflow is set exactly when that total exceeds 511.
  task automatic test_random_batches();
    int total;
    int p;
    int waitCycles;
    for (int b = 0; b < 8; b++) begin
      total = 0;
      for (int k = 0; k < 4; k++) begin
        busB.in_valid = 1'b0;
        for (int g = 0; g < int'($urandom_range(0, 2)); g++) begin
          tick();
          nTests++; if (busB.sum !== 9'(total % 512)) begin nFail++; $display("[TB] FAIL rnd_idle_sum[%0d]: got %0d expected %0d", b, busB.sum, total % 512); end
        end
        p = int'($urandom_range(0, 255));
        busB.in_valid = 1'b1;
        busB.product  = 8'(p);
        tick();
        total += p;
        nTests++; if (busB.count !== 4'((k + 1) % 4)) begin nFail++; $display("[TB] FAIL rnd_count[%0d.%0d]: got %0d expected %0d", b, k, busB.count, (k + 1) % 4); end
      end
      busB.in_valid = 1'b0;
      nTests++; if (busB.out_valid !== 1'b1) begin nFail++; $display("[TB] FAIL rnd_out_valid[%0d]: got %0d expected 1", b, busB.out_valid); end
      nTests++; if (busB.sum !== 9'(total % 512)) begin nFail++; $display("[TB] FAIL rnd_sum[%0d]: got %0d expected %0d", b, busB.sum, total % 512); end
      nTests++; if (busB.overflow !== (total > 511)) begin nFail++; $display("[TB] FAIL rnd_overflow[%0d]: got %0d expected %0d", b, busB.overflow, total > 511); end
      waitCycles = int'($urandom_range(0, 3));
      for (int w = 0; w < waitCycles; w++) begin
        busB.in_valid = 1'b1;
        busB.product  = 8'($urandom_range(1, 255));
        tick();
        nTests++; if (busB.sum !== 9'(total % 512)) begin nFail++; $display("[TB] FAIL rnd_hold_sum[%0d]: got %0d expected %0d", b, busB.sum, total % 512); end
      end
      busB.in_valid  = 1'b0;
      busB.out_ready = 1'b1;
      tick();
      busB.out_ready = 1'b0;
      nTests++; if (busB.out_valid !== 1'b0 || busB.sum !== 9'd0 || busB.overflow !== 1'b0) begin nFail++; $display("[TB] FAIL rnd_release[%0d]: got valid %0d sum %0d ovf %0d expected 0 0 0", b, busB.out_valid, busB.sum, busB.overflow); end
    end
  endtask

  initial begin
    nTests = 0;
    nFail  = 0;
    rst    = 1'b1;
    busA.in_valid = 1'b0; busA.product = 8'd0; busA.out_ready = 1'b0;
    busB.in_valid = 1'b0; busB.product = 8'd0; busB.out_ready = 1'b0;
    tick();
    test_reset();
    test_basic_batch();
    test_backpressure();
    test_gapped();
    test_reset_mid_batch();
    test_overflow();
    test_back_to_back();
    test_random_batches();
    $display("[TB] %0d tests run, %0d failed", nTests, nFail);
    $finish;
  end

endmodule
